// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader side uses the slave modport; the byte source/memory side uses master.
interface imem_loader_if #(
  parameter int AW = 10
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory and releases the CPU.
// Defining IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte that must match the data.
module imem_loader #(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int TIMEOUT = 1048575
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_rst,
  output logic         busy,
  output logic         done,
  output logic         err
);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
  localparam logic [19:0] TO      = 20'(TIMEOUT);

  state_t        state, next;
  logic [7:0]    lo_q;
  logic [15:0]   n_q;
  logic [15:0]   n_new;
  logic [1:0]    lane_q;
  logic [31:0]   word_q;
  logic [31:0]   wdata_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [19:0]   idle_q;
  logic          xfer, hdr_ok, last_word, timed_out;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum_q;
`endif

  assign busy    = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CSUM);
  assign done    = (state == DONE);
  assign err     = (state == ERR);
  assign cpu_rst = (state != DONE);

  // No byte is taken in the write cycle, so a word never overlaps its own write.
  assign bus.in_ready   = busy && !we_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign n_new     = {bus.in_data, lo_q};
  assign hdr_ok    = (n_new != 16'd0) && ({16'd0, n_new} <= DEPTH_U);
  assign last_word = (32'(addr_q) + 32'd1) == {16'd0, n_q};
  assign timed_out = busy && !xfer && (idle_q == TO);

  always_comb begin
    next = state;
    case (state)
      IDLE, DONE, ERR: if (start) next = HDR0;
      HDR0:            if (xfer) next = HDR1;
      HDR1:            if (xfer) next = hdr_ok ? DATA : ERR;
`ifdef IMEM_LOADER_CHECKSUM_EN
      DATA:            if (we_q && last_word) next = CSUM;
      CSUM:            if (xfer) next = (bus.in_data == csum_q) ? DONE : ERR;
`else
      DATA:            if (we_q && last_word) next = DONE;
`endif
      default:         next = IDLE;
    endcase
    if (timed_out) next = ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lo_q    <= '0;
      n_q     <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      idle_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state  <= next;
      we_q   <= 1'b0;
      idle_q <= (busy && !xfer) ? idle_q + 20'd1 : 20'd0;

      // A fresh load starts from word 0 with an empty lane, dropping any leftover partial word.
      if (!busy && next == HDR0) begin
        lane_q <= '0;
        word_q <= '0;
        addr_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q <= '0;
`endif
      end

      if (xfer) begin
        case (state)
          HDR0: lo_q <= bus.in_data;
          HDR1: n_q  <= n_new;
          DATA: begin
            word_q <= {bus.in_data, word_q[31:8]};
            lane_q <= lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ bus.in_data;
`endif
            if (lane_q == 2'd3) begin
              we_q    <= 1'b1;
              wdata_q <= {bus.in_data, word_q[31:8]};
            end
          end
          default: ;
        endcase
      end

      if (we_q && !last_word) addr_q <= addr_q + AW'(1);
    end
  end
endmodule
